hazard_stall_controller: RTL and testbench

- Pipeline sequencer for the 5-stage rv32i core.
- Detects load-use hazards and decode-stage branch-operand hazards, then generates the stage-register load enables, ID/EX bubble and IF/ID flush.
- Drives stall_br_haz1/stall_br_haz2 into the forwarding unit.
- Freezes the whole pipeline on instruction or data memory waits, and keeps stall/flush performance counters.

---
 rtl/hazard_stall_controller.sv | 130 +++++++++++++
 tb/tb_hazard_stall_controller.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencer for the 5-stage rv32i core: load-use and decode-branch hazard
// detection, stage enables, bubble/flush generation, memory-wait freeze and perf counters.
module hazard_stall_controller #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           REGFILE_rs1_i,
  input  logic [4:0]           REGFILE_rs2_i,
  input  logic                 ID_use_rs1_i,
  input  logic                 ID_use_rs2_i,
  input  logic                 ID_is_branch_i,
  input  logic                 br_taken_i,
  input  logic [4:0]           ID_EX_rd_i,
  input  logic                 EX_load_regfile_i,
  input  logic                 ID_EX_is_load_i,
  input  logic [4:0]           EX_MEM_rd_i,
  input  logic                 EX_MEM_is_load_i,
  input  logic                 imem_busy_i,
  input  logic                 dmem_busy_i,
  output logic                 pc_load_o,
  output logic                 IF_ID_load_o,
  output logic                 ID_EX_load_o,
  output logic                 EX_MEM_load_o,
  output logic                 MEM_WB_load_o,
  output logic                 ID_EX_bubble_o,
  output logic                 IF_ID_flush_o,
  output logic                 stall_br_haz1_o,
  output logic                 stall_br_haz2_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o,
  output logic [CNT_WIDTH-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {RUN, BR1, BR2} state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0]  flush_cnt_q, flush_cnt_d;

  logic match_ex, match_mem;
  logic lu, bh_ex_alu, bh_ex_ld, bh_mem_ld, br_haz, freeze, hz;

  // x0 is hardwired zero, so it can never be the source of a hazard.
  assign match_ex  = (ID_EX_rd_i != 5'd0) &
                     ((ID_use_rs1_i & (REGFILE_rs1_i == ID_EX_rd_i)) |
                      (ID_use_rs2_i & (REGFILE_rs2_i == ID_EX_rd_i)));
  assign match_mem = (EX_MEM_rd_i != 5'd0) &
                     ((ID_use_rs1_i & (REGFILE_rs1_i == EX_MEM_rd_i)) |
                      (ID_use_rs2_i & (REGFILE_rs2_i == EX_MEM_rd_i)));

  assign lu        = ID_EX_is_load_i & match_ex & ~ID_is_branch_i;
  assign bh_ex_alu = ID_is_branch_i & EX_load_regfile_i & ~ID_EX_is_load_i & match_ex;
  assign bh_ex_ld  = ID_is_branch_i & ID_EX_is_load_i & match_ex;
  assign bh_mem_ld = ID_is_branch_i & EX_MEM_is_load_i & match_mem;
  assign br_haz    = bh_ex_alu | bh_ex_ld | bh_mem_ld;
  assign freeze    = imem_busy_i | dmem_busy_i;

  always_comb begin
    state_d = state_q;
    hz      = 1'b0;
    case (state_q)
      RUN: begin
        hz = lu | br_haz;
        if (!freeze && br_haz) state_d = BR1;
      end
      BR1: begin
        hz = bh_mem_ld;
        if (!freeze) state_d = bh_mem_ld ? BR2 : RUN;
      end
      BR2: begin
        // The load has reached WB and is forwardable, so no further hold.
        if (!freeze) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pc_load_o      = 1'b0;
    IF_ID_load_o   = 1'b0;
    ID_EX_load_o   = 1'b0;
    EX_MEM_load_o  = 1'b0;
    MEM_WB_load_o  = 1'b0;
    ID_EX_bubble_o = 1'b0;
    IF_ID_flush_o  = 1'b0;
    if (rst || freeze) begin
      // Everything held; freeze outranks any hazard.
    end else if (hz) begin
      ID_EX_load_o   = 1'b1;
      EX_MEM_load_o  = 1'b1;
      MEM_WB_load_o  = 1'b1;
      ID_EX_bubble_o = 1'b1;
    end else begin
      pc_load_o      = 1'b1;
      IF_ID_load_o   = 1'b1;
      ID_EX_load_o   = 1'b1;
      EX_MEM_load_o  = 1'b1;
      MEM_WB_load_o  = 1'b1;
      IF_ID_flush_o  = ID_is_branch_i & br_taken_i;
    end
  end

  assign stall_br_haz1_o = ~rst & (state_q == BR1);
  assign stall_br_haz2_o = ~rst & (state_q == BR2);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_load_o && (stall_cnt_q != {CNT_WIDTH{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (IF_ID_flush_o && (flush_cnt_q != {CNT_WIDTH{1'b1}}))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller; narrow counters make saturation reachable.
module tb_hazard_stall_controller;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    rs1, rs2, id_ex_rd, ex_mem_rd;
  logic          use_rs1, use_rs2, is_branch, br_taken;
  logic          ex_load_rf, id_ex_is_load, ex_mem_is_load;
  logic          imem_busy, dmem_busy;
  logic          pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
  logic          bubble, flush, haz1, haz2;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_stall_controller #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .REGFILE_rs1_i(rs1), .REGFILE_rs2_i(rs2),
    .ID_use_rs1_i(use_rs1), .ID_use_rs2_i(use_rs2),
    .ID_is_branch_i(is_branch), .br_taken_i(br_taken),
    .ID_EX_rd_i(id_ex_rd), .EX_load_regfile_i(ex_load_rf), .ID_EX_is_load_i(id_ex_is_load),
    .EX_MEM_rd_i(ex_mem_rd), .EX_MEM_is_load_i(ex_mem_is_load),
    .imem_busy_i(imem_busy), .dmem_busy_i(dmem_busy),
    .pc_load_o(pc_load), .IF_ID_load_o(if_id_load), .ID_EX_load_o(id_ex_load),
    .EX_MEM_load_o(ex_mem_load), .MEM_WB_load_o(mem_wb_load),
    .ID_EX_bubble_o(bubble), .IF_ID_flush_o(flush),
    .stall_br_haz1_o(haz1), .stall_br_haz2_o(haz2),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-14s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Packs {pc, if_id, id_ex, ex_mem, mem_wb, bubble, flush} for one-shot comparison.
  function automatic logic [6:0] ctl();
    return {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load, bubble, flush};
  endfunction

  task automatic idle();
    rs1 = 0; rs2 = 0; use_rs1 = 0; use_rs2 = 0; is_branch = 0; br_taken = 0;
    id_ex_rd = 0; ex_load_rf = 0; id_ex_is_load = 0;
    ex_mem_rd = 0; ex_mem_is_load = 0; imem_busy = 0; dmem_busy = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [6:0] NORMAL = 7'b1111100;
  localparam logic [6:0] NFLUSH = 7'b1111101;
  localparam logic [6:0] HSTALL = 7'b0011110;
  localparam logic [6:0] FROZEN = 7'b0000000;

  initial begin
    idle();
    rst = 1'b1;
    #1;
    chk("rst_ctl", ctl(), FROZEN);
    step(); step();
    chk("rst_flags", {haz1, haz2}, 2'b00);
    chk("rst_cnt", {stall_cnt, flush_cnt}, 8'h00);
    rst = 1'b0;
    #1;
    chk("idle_ctl", ctl(), NORMAL);

    // lw x5 in EX, add x6,x5,x1 in decode
    id_ex_rd = 5; id_ex_is_load = 1; ex_load_rf = 1;
    rs1 = 5; rs2 = 1; use_rs1 = 1; use_rs2 = 1;
    #1; chk("lu_stall", ctl(), HSTALL);
    step();
    idle(); ex_mem_rd = 5; ex_mem_is_load = 1; rs1 = 5; use_rs1 = 1;
    #1; chk("lu_after", ctl(), NORMAL);
    chk("lu_cnt", stall_cnt, 1);
    chk("lu_noflag", haz1, 0);

    // lw x5 in EX, beq x5,x0 in decode: two stall cycles
    idle(); id_ex_rd = 5; id_ex_is_load = 1; ex_load_rf = 1;
    is_branch = 1; rs1 = 5; rs2 = 0; use_rs1 = 1; use_rs2 = 1;
    #1; chk("exld_c0", ctl(), HSTALL);
    step();
    id_ex_rd = 0; id_ex_is_load = 0; ex_load_rf = 0; ex_mem_rd = 5; ex_mem_is_load = 1;
    #1; chk("exld_c1", ctl(), HSTALL);
    chk("exld_c1_fl", {haz1, haz2}, 2'b10);
    step();
    ex_mem_rd = 0; ex_mem_is_load = 0;
    #1; chk("exld_c2", ctl(), NORMAL);
    chk("exld_c2_fl", {haz1, haz2}, 2'b01);
    chk("exld_cnt", stall_cnt, 3);
    step(); idle();
    #1; chk("exld_done", {haz1, haz2}, 2'b00);

    // addi x7 in EX, taken bne x7,x2: flush held off during the stall cycle
    id_ex_rd = 7; ex_load_rf = 1; is_branch = 1; br_taken = 1;
    rs1 = 7; rs2 = 2; use_rs1 = 1; use_rs2 = 1;
    #1; chk("alu_c0", ctl(), HSTALL);
    step();
    id_ex_rd = 0; ex_load_rf = 0; ex_mem_rd = 7;
    #1; chk("alu_c1", ctl(), NFLUSH);
    chk("alu_c1_fl", {haz1, haz2}, 2'b10);
    chk("alu_cnt", {stall_cnt, flush_cnt}, {4'd4, 4'd0});
    step(); idle();
    #1; chk("alu_run", {haz1, haz2, flush_cnt}, {2'b00, 4'd1});

    // taken beq with no hazard
    is_branch = 1; br_taken = 1; rs1 = 3; use_rs1 = 1;
    #1; chk("tkn_ctl", ctl(), NFLUSH);
    step(); idle();
    #1; chk("tkn_cnt", flush_cnt, 2);

    // lw x5 feeding branch, dmem wait for 3 cycles while in BR1
    id_ex_rd = 5; id_ex_is_load = 1; ex_load_rf = 1; is_branch = 1; rs1 = 5; use_rs1 = 1;
    #1; chk("frz_c0", ctl(), HSTALL);
    step();
    id_ex_rd = 0; id_ex_is_load = 0; ex_load_rf = 0; ex_mem_rd = 5; ex_mem_is_load = 1;
    dmem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      #1; chk("frz_ctl", ctl(), FROZEN);
      chk("frz_hold", {haz1, haz2}, 2'b10);
      step();
    end
    dmem_busy = 0;
    #1; chk("frz_br1", ctl(), HSTALL);
    chk("frz_cnt", stall_cnt, 8);
    step();
    ex_mem_rd = 0; ex_mem_is_load = 0;
    #1; chk("frz_br2", {haz1, haz2, ctl()}, {2'b01, NORMAL});
    step(); idle();
    #1; chk("frz_end", {haz1, haz2, stall_cnt}, {2'b00, 4'd9});

    // reset while in BR1
    id_ex_rd = 5; id_ex_is_load = 1; is_branch = 1; rs1 = 5; use_rs1 = 1;
    step();
    id_ex_rd = 0; id_ex_is_load = 0; ex_mem_rd = 5; ex_mem_is_load = 1;
    #1; chk("rb_br1", haz1, 1);
    rst = 1;
    #1; chk("rb_ctl", {ctl(), haz1, haz2}, 9'd0);
    step();
    rst = 0; idle();
    #1; chk("rb_after", {haz1, haz2, ctl()}, {2'b00, NORMAL});
    chk("rb_cnt", {stall_cnt, flush_cnt}, 8'h00);

    // x0 destinations never stall
    id_ex_rd = 0; id_ex_is_load = 1; rs1 = 0; use_rs1 = 1;
    #1; chk("x0_lu", ctl(), NORMAL);
    idle(); is_branch = 1; ex_mem_is_load = 1; ex_mem_rd = 0; rs2 = 0; use_rs2 = 1;
    #1; chk("x0_br", ctl(), NORMAL);

    // freeze outranks a branch hazard and holds RUN
    idle(); id_ex_rd = 9; ex_load_rf = 1; is_branch = 1; br_taken = 1; rs2 = 9; use_rs2 = 1;
    imem_busy = 1;
    #1; chk("fzh_ctl", ctl(), FROZEN);
    step();
    #1; chk("fzh_state", {haz1, haz2, stall_cnt}, {2'b00, 4'd1});

    // long freeze drives stall_cnt into saturation
    for (int i = 0; i < 20; i++) step();
    #1; chk("sat_cnt", stall_cnt, 15);
    idle();
    step();
    #1; chk("sat_hold", stall_cnt, 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
